// File: rtl/flog_param_top.sv
// Floating-point log2 / ln / log10 with configurable exponent and fraction widths.
// Iterative squaring mantissa log, fixed-to-float normalise, constant scale, RNE round.
module flog_param_top #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7,
  parameter int GUARD       = 3,
  parameter int BIAS        = 2**(EXP_WIDTH-1)-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sign,
  input  logic [EXP_WIDTH-1:0]   exponent,
  input  logic [FRACT_WIDTH-1:0] fractional,
  input  logic [1:0]             mode_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   s_res_o,
  output logic [EXP_WIDTH-1:0]   e_res_o,
  output logic [FRACT_WIDTH-1:0] f_res_o,
  output logic [2:0]             flags_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int L     = FRACT_WIDTH + GUARD;
  localparam int W     = EXP_WIDTH + 1 + L;
  localparam int CW    = L + 2;
  localparam int PW    = W + CW;
  localparam int CNT_W = $clog2(L + 1);
  localparam int POS_W = $clog2(W);

  // ln2 and log10(2) as 32-bit binary fractions, truncated to CW bits below
  localparam logic [31:0]   LN2_K     = 32'hB172_17F7;
  localparam logic [31:0]   LOG10_2_K = 32'h4D10_4D42;
  localparam logic [CW-1:0] C_LN2     = CW'(LN2_K >> (32 - CW));
  // log10(2) is held doubled so both constants lie in [0.5,1); the exponent absorbs the extra 1
  localparam logic [CW-1:0] C_LOG10   = CW'((LOG10_2_K >> (32 - CW)) << 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ITER, S_NORM, S_SCALE, S_ROUND, S_OUT
  } state_t;

  state_t r_state, w_next;

  logic                   r_sign;
  logic [EXP_WIDTH-1:0]   r_exp;
  logic [FRACT_WIDTH-1:0] r_frac;
  logic [1:0]             r_mode;
  logic [L:0]             r_y;
  logic [L-1:0]           r_flog;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_neg;
  logic                   r_zero;
  logic                   r_sticky;
  logic [W-1:0]           r_mant;
  logic [EXP_WIDTH-1:0]   r_eres;
  logic                   r_s_res;
  logic [EXP_WIDTH-1:0]   r_e_res;
  logic [FRACT_WIDTH-1:0] r_f_res;
  logic [2:0]             r_flags;
  logic                   r_valid;

  logic                   w_accept;
  logic                   w_snan, w_qnan, w_zero, w_special;
  logic                   w_sp_s;
  logic [EXP_WIDTH-1:0]   w_sp_e;
  logic [FRACT_WIDTH-1:0] w_sp_f;
  logic [2:0]             w_sp_flags;
  logic [2*L+1:0]         w_sq;
  logic [L+1:0]           w_y2;
  logic                   w_bit;
  logic [L:0]             w_ynext;
  logic [EXP_WIDTH:0]     w_eunb;
  logic signed [W-1:0]    w_v;
  logic [W-1:0]           w_mag;
  logic [POS_W-1:0]       w_pos;
  logic [W-1:0]           w_norm;
  logic [EXP_WIDTH-1:0]   w_enorm;
  logic                   w_do_scale;
  logic [CW-1:0]          w_const;
  logic [PW-1:0]          w_prod;
  logic [W-1:0]           w_smant;
  logic                   w_slost;
  logic [EXP_WIDTH-1:0]   w_sadj;
  logic [EXP_WIDTH+FRACT_WIDTH:0] w_rnd;

  // Round-to-nearest-even of the fraction below the hidden one; returns {nx, exp, frac}
  function automatic logic [EXP_WIDTH+FRACT_WIDTH:0] round_rne(
    input logic [W-2:0]         frac_in,
    input logic [EXP_WIDTH-1:0] e_in,
    input logic                 sticky_in
  );
    logic [FRACT_WIDTH-1:0] kept;
    logic                   g, s, up;
    logic [FRACT_WIDTH:0]   sum;
    logic [EXP_WIDTH-1:0]   e_out;
    kept  = frac_in[W-2 -: FRACT_WIDTH];
    g     = frac_in[W-2-FRACT_WIDTH];
    s     = (|frac_in[W-3-FRACT_WIDTH:0]) | sticky_in;
    up    = g & (s | kept[0]);
    sum   = {1'b0, kept} + {{FRACT_WIDTH{1'b0}}, up};
    e_out = e_in + {{(EXP_WIDTH-1){1'b0}}, sum[FRACT_WIDTH]};
    return {g | s, e_out, sum[FRACT_WIDTH-1:0]};
  endfunction

  assign w_accept = valid_i && ready_o;

  // Operand classification and special-case results
  always_comb begin
    w_snan     = (&r_exp) && !r_frac[FRACT_WIDTH-1] && (|r_frac);
    w_qnan     = (&r_exp) && r_frac[FRACT_WIDTH-1];
    w_zero     = ~|r_exp;
    w_special  = (&r_exp) || w_zero || r_sign;
    w_sp_s     = 1'b0;
    w_sp_e     = '1;
    w_sp_f     = '0;
    w_sp_flags = 3'b000;
    if (w_snan) begin
      w_sp_f     = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
      w_sp_flags = 3'b100;
    end else if (w_qnan) begin
      w_sp_f     = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
    end else if (w_zero) begin
      w_sp_s     = 1'b1;
      w_sp_flags = 3'b010;
    end else if (r_sign) begin
      w_sp_f     = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
      w_sp_flags = 3'b100;
    end
  end

  // ITER: one squaring per cycle, the integer carry of y*y is the next log bit
  always_comb begin
    w_sq    = (2*L+2)'(r_y) * (2*L+2)'(r_y);
    w_y2    = (L+2)'(w_sq >> L);
    w_bit   = w_y2[L+1];
    w_ynext = w_bit ? w_y2[L+1:1] : w_y2[L:0];
  end

  // NORM: signed fixed-point log to sign/magnitude, then leading-one normalise
  always_comb begin
    w_eunb  = {1'b0, r_exp} - (EXP_WIDTH+1)'(BIAS);
    w_v     = {w_eunb, r_flog};
    w_mag   = w_v[W-1] ? (~w_v + W'(1)) : w_v;
    w_pos   = '0;
    for (int i = 0; i < W; i++) begin
      if (w_mag[i]) w_pos = POS_W'(i);
    end
    w_norm  = w_mag << (POS_W'(W-1) - w_pos);
    w_enorm = EXP_WIDTH'(BIAS - L) + EXP_WIDTH'(w_pos);
  end

  // SCALE: product lies in [0.5,2), so at most one renormalising shift
  always_comb begin
    w_do_scale = (r_mode == 2'b01) || (r_mode == 2'b10);
    w_const    = (r_mode == 2'b01) ? C_LN2 : C_LOG10;
    w_prod     = PW'(r_mant) * PW'(w_const);
    w_smant    = w_prod[PW-1] ? w_prod[PW-1 -: W] : w_prod[PW-2 -: W];
    w_slost    = w_prod[PW-1] ? (|w_prod[CW-1:0]) : (|w_prod[CW-2:0]);
    w_sadj     = EXP_WIDTH'({(r_mode == 2'b10), !w_prod[PW-1]} == 2'b11 ? 2 :
                            ((r_mode == 2'b10) || !w_prod[PW-1]) ? 1 : 0);
  end

  assign w_rnd = round_rne(r_mant[W-2:0], r_eres, r_sticky);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CHECK;
      S_CHECK: w_next = w_special ? S_OUT : S_ITER;
      S_ITER:  if (r_cnt == CNT_W'(L-1)) w_next = S_NORM;
      S_NORM:  w_next = S_SCALE;
      S_SCALE: w_next = S_ROUND;
      S_ROUND: w_next = S_OUT;
      S_OUT:   if (r_valid && ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = rst && (r_state == S_IDLE);
    valid_o = r_valid;
    s_res_o = r_s_res;
    e_res_o = r_e_res;
    f_res_o = r_f_res;
    flags_o = r_flags;
  end

  // Control, iteration counter and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_s_res <= 1'b0;
      r_e_res <= '0;
      r_f_res <= '0;
      r_flags <= '0;
    end else begin
      r_valid <= (r_state == S_OUT) && !(r_valid && ready_i);
      case (r_state)
        S_IDLE: if (w_accept) r_flags <= '0;
        S_CHECK: begin
          r_cnt <= '0;
          if (w_special) begin
            r_s_res <= w_sp_s;
            r_e_res <= w_sp_e;
            r_f_res <= w_sp_f;
            r_flags <= w_sp_flags;
          end
        end
        S_ITER: r_cnt <= r_cnt + CNT_W'(1);
        S_ROUND: begin
          if (r_zero) begin
            r_s_res <= 1'b0;
            r_e_res <= '0;
            r_f_res <= '0;
            r_flags <= '0;
          end else begin
            r_s_res <= r_neg;
            r_e_res <= w_rnd[EXP_WIDTH+FRACT_WIDTH-1:FRACT_WIDTH];
            r_f_res <= w_rnd[FRACT_WIDTH-1:0];
            r_flags <= {2'b00, w_rnd[EXP_WIDTH+FRACT_WIDTH]};
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          r_sign <= sign;
          r_exp  <= exponent;
          r_frac <= fractional;
          r_mode <= mode_i;
        end
      end
      S_CHECK: begin
        r_y    <= (L+1)'({1'b1, r_frac}) << GUARD;
        r_flog <= '0;
      end
      S_ITER: begin
        r_y    <= w_ynext;
        r_flog <= {r_flog[L-2:0], w_bit};
      end
      S_NORM: begin
        r_neg    <= w_v[W-1];
        r_zero   <= (w_mag == '0);
        r_mant   <= w_norm;
        r_eres   <= w_enorm;
        r_sticky <= 1'b0;
      end
      S_SCALE: begin
        if (w_do_scale) begin
          r_mant   <= w_smant;
          r_eres   <= r_eres - w_sadj;
          r_sticky <= w_slost;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flog_param_top.sv
// Directed bench for flog_param_top at default parameters (bfloat16 layout, L=10).
module tb_flog_param_top;

  logic       clk = 1'b0;
  logic       rst, sign, valid_i, ready_i;
  logic [7:0] exponent;
  logic [6:0] fractional;
  logic [1:0] mode_i;
  logic       ready_o, s_res_o, valid_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic [2:0] flags_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flog_param_top dut (
    .clk(clk), .rst(rst), .sign(sign), .exponent(exponent), .fractional(fractional),
    .mode_i(mode_i), .valid_i(valid_i), .ready_o(ready_o), .s_res_o(s_res_o),
    .e_res_o(e_res_o), .f_res_o(f_res_o), .flags_o(flags_o), .valid_o(valid_o),
    .ready_i(ready_i)
  );

  typedef struct {
    logic [15:0] op;
    logic [1:0]  mode;
    logic [15:0] res;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs [0:13];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic send(input logic [15:0] op, input logic [1:0] mode);
    int t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait", 32'(ready_o), 32'd1);
    sign       = op[15];
    exponent   = op[14:7];
    fractional = op[6:0];
    mode_i     = mode;
    valid_i    = 1'b1;
    @(posedge clk); #1;
    valid_i    = 1'b0;
    sign       = ~sign;
    exponent   = ~exponent;
    fractional = ~fractional;
    mode_i     = ~mode_i;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!valid_o && lat < 100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int stray;
    vecs[0]  = '{16'h3F80, 2'd0, 16'h0000, 3'b000, 15};
    vecs[1]  = '{16'h4100, 2'd0, 16'h4040, 3'b000, 15};
    vecs[2]  = '{16'h3F00, 2'd0, 16'hBF80, 3'b000, 15};
    vecs[3]  = '{16'h4000, 2'd1, 16'h3F31, 3'b001, 15};
    vecs[4]  = '{16'h4000, 2'd3, 16'h3F80, 3'b000, 15};
    vecs[5]  = '{16'h4080, 2'd1, 16'h3FB1, 3'b001, 15};
    vecs[6]  = '{16'h4000, 2'd2, 16'h3E9A, 3'b001, 15};
    vecs[7]  = '{16'h4040, 2'd0, 16'h3FCB, 3'b001, 15};
    vecs[8]  = '{16'h0000, 2'd0, 16'hFF80, 3'b010, 2};
    vecs[9]  = '{16'h8000, 2'd0, 16'hFF80, 3'b010, 2};
    vecs[10] = '{16'hFF80, 2'd0, 16'h7FC0, 3'b100, 2};
    vecs[11] = '{16'h7F81, 2'd0, 16'h7FC0, 3'b100, 2};
    vecs[12] = '{16'h7F80, 2'd0, 16'h7F80, 3'b000, 2};
    vecs[13] = '{16'h7FC0, 2'd0, 16'h7FC0, 3'b000, 2};

    sign = 1'b0; exponent = '0; fractional = '0; mode_i = 2'd0;
    valid_i = 1'b0; ready_i = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_res", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
    check("rst_flags", 32'(flags_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 32'(ready_o), 32'd1);

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].op, vecs[i].mode);
      wait_valid(lat);
      check($sformatf("lat_%0d", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("res_%0d", i), 32'({s_res_o, e_res_o, f_res_o}), 32'(vecs[i].res));
      check($sformatf("flg_%0d", i), 32'(flags_o), 32'(vecs[i].flg));
      @(posedge clk); #1;
      check($sformatf("vdrop_%0d", i), 32'(valid_o), 32'd0);
      check($sformatf("rdy_%0d", i), 32'(ready_o), 32'd1);
    end

    // Output backpressure with an ignored operand offered while busy
    ready_i = 1'b0;
    send(16'h4000, 2'd1);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd15);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bp_res_%0d", k), 32'({s_res_o, e_res_o, f_res_o}), 32'h3F31);
      check($sformatf("bp_flg_%0d", k), 32'(flags_o), 32'b001);
      check($sformatf("bp_vld_%0d", k), 32'(valid_o), 32'd1);
      check($sformatf("bp_rdy_%0d", k), 32'(ready_o), 32'd0);
      if (k == 1) begin
        sign = 1'b0; exponent = 8'h7E; fractional = 7'h00; mode_i = 2'd0;
        valid_i = 1'b1;
      end
      if (k == 4) valid_i = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_res_end", 32'({s_res_o, e_res_o, f_res_o}), 32'h3F31);
    ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_vdrop", 32'(valid_o), 32'd0);
    check("bp_rdy_back", 32'(ready_o), 32'd1);
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid_o || !ready_o) stray++;
    end
    check("bp_no_accept", 32'(stray), 32'd0);

    // Asynchronous reset in the middle of ITER
    send(16'h4100, 2'd0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_res", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
    check("mid_rst_vld", 32'(valid_o), 32'd0);
    check("mid_rst_rdy", 32'(ready_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_rdy_hold", 32'(ready_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rdy", 32'(ready_o), 32'd1);
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid_o) stray++;
    end
    check("post_rst_no_vld", 32'(stray), 32'd0);
    send(16'h4100, 2'd0);
    wait_valid(lat);
    check("post_rst_lat", 32'(lat), 32'd15);
    check("post_rst_res", 32'({s_res_o, e_res_o, f_res_o}), 32'h4040);
    check("post_rst_flg", 32'(flags_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
